// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad decode path.
// Contents: FSM state enum, key/position widths, one-hot classification helper.
// Used by: keypad_decoder (keypad_fifo is type-agnostic).
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int POS_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    typedef struct packed {
        logic             is_onehot;
        logic [KEY_W-1:0] code;
    } onehot_t;

    // code is the index of the highest set bit; it is only meaningful when
    // is_onehot is set, in which case it is the index of the single set bit.
    function automatic onehot_t onehot_to_code(input logic [POS_W-1:0] pos);
        onehot_t r;
        int      ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < POS_W; i++) begin
            if (pos[i]) begin
                ones   = ones + 1;
                r.code = KEY_W'(i);
            end
        end
        r.is_onehot = (ones == 1);
        return r;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Purpose: small first-word-fall-through FIFO for decoded key events.
// Latency: a push is visible at head the cycle after the pushing edge.
// Backpressure: push is accepted when not full, or when full with a pop on the same edge.
// Ports: clk/rst (sync, active-high); push + push_data write side;
//        pop read side (ignored while empty); full, empty, head status/data.
module keypad_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    // Last value popped: head holds it while the FIFO is empty.
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // When full, a same-edge pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Purpose: debounce a one-hot keypad position word and queue one 4-bit code per press.
// Latency: a key stable for DEBOUNCE_CYCLES edges is pushed on the last edge, visible next cycle.
// Backpressure: key_valid/key_ready handshake; presses arriving while the FIFO is full are dropped and set overflow.
// Ports: clk/rst (sync, active-high); posicion one-hot key word in;
//        key_code/key_valid/key_ready event out; multi_key, overflow status flags.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] posicion,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             multi_key,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [KEY_W-1:0] cand;
    logic [KEY_W-1:0] cand_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             is_zero;
    onehot_t          pos_info;

    assign pos_info  = onehot_to_code(posicion);
    assign is_zero   = (posicion == '0);
    assign key_valid = !fifo_empty;
    assign pop       = key_valid && key_ready;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (pos_info.is_onehot) begin
                    cand_n  = pos_info.code;
                    cnt_n   = CNT_W'(1);
                    state_n = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (pos_info.is_onehot && (pos_info.code == cand)) begin
                    if (cnt == CNT_LAST) begin
                        push    = 1'b1;
                        state_n = PRESSED;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (pos_info.is_onehot) begin
                    // A different single key restarts the debounce on that key.
                    cand_n = pos_info.code;
                    cnt_n  = CNT_W'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            PRESSED: begin
                // No rollover: anything non-zero keeps us waiting for a release.
                if (is_zero) begin
                    cnt_n   = CNT_W'(1);
                    state_n = DEB_REL;
                end
            end
            DEB_REL: begin
                if (is_zero) begin
                    if (cnt == CNT_LAST) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    state_n = PRESSED;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            multi_key <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            multi_key <= !is_zero && !pos_info.is_onehot;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    keypad_fifo #(
        .WIDTH(KEY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(cand),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (key_code)
    );

endmodule

// File: tb/tb_keypad_decoder.sv
module tb_keypad_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] posicion;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        multi_key;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    keypad_decoder #(
        .DEBOUNCE_CYCLES(16),
        .FIFO_DEPTH     (4),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .posicion (posicion),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .multi_key(multi_key),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [15:0] pos, input int n);
        posicion = pos;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full debounced press followed by a full debounced release.
    task automatic press(input logic [15:0] pos);
        hold(pos, 16);
        hold(16'h0000, 16);
    endtask

    initial begin
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd1, 4'd2, 4'd3, 4'd4};

        rst       = 1'b1;
        posicion  = 16'h0000;
        key_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_valid", key_valid, 0);
        check("reset_code", key_code, 0);
        check("reset_multi", multi_key, 0);
        check("reset_ovf", overflow, 0);

        // Single press of key 5: pushed on exactly the 16th edge.
        hold(16'h0020, 15);
        check("t1_valid_at_15", key_valid, 0);
        tick();
        check("t1_valid_at_16", key_valid, 1);
        check("t1_code", key_code, 5);
        hold(16'h0020, 20);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("t1_single_entry", key_valid, 0);
        hold(16'h0000, 16);

        // Short burst is rejected; a later full press gives one event.
        hold(16'h0020, 10);
        hold(16'h0000, 1);
        check("t2_burst_none", key_valid, 0);
        hold(16'h0020, 15);
        check("t2_valid_at_15", key_valid, 0);
        tick();
        check("t2_valid", key_valid, 1);
        check("t2_code", key_code, 5);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("t2_single_entry", key_valid, 0);
        hold(16'h0000, 16);

        // In-order delivery with key_ready held high (ignored while empty).
        key_ready = 1'b1;
        hold(16'h0001, 16);
        check("t3_first_valid", key_valid, 1);
        check("t3_first_code", key_code, 0);
        tick();
        check("t3_first_popped", key_valid, 0);
        hold(16'h0000, 16);
        hold(16'h8000, 16);
        check("t3_second_valid", key_valid, 1);
        check("t3_second_code", key_code, 15);
        tick();
        check("t3_second_popped", key_valid, 0);
        check("t3_code_holds", key_code, 15);
        key_ready = 1'b0;
        hold(16'h0000, 16);

        // Multi-key: flag next cycle, nothing pushed, FSM remains idle.
        posicion = 16'h0011;
        tick();
        check("t4_multi_set", multi_key, 1);
        hold(16'h0011, 20);
        check("t4_no_push", key_valid, 0);
        hold(16'h0000, 1);
        check("t4_multi_clr", multi_key, 0);
        hold(16'h0020, 15);
        check("t4_idle_at_15", key_valid, 0);
        tick();
        check("t4_idle_at_16", key_valid, 1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        hold(16'h0000, 16);

        // Overflow: five presses into a depth-4 FIFO.
        press(16'h0002);
        press(16'h0004);
        press(16'h0008);
        press(16'h0010);
        check("t5_ovf_after_4", overflow, 0);
        press(16'h0040);
        check("t5_ovf_after_5", overflow, 1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_drain_valid%0d", i), key_valid, 1);
            check($sformatf("t5_drain_code%0d", i), key_code, exp_codes[i]);
            tick();
        end
        check("t5_drained", key_valid, 0);
        check("t5_ovf_sticky", overflow, 1);
        key_ready = 1'b0;

        // Reset mid-debounce with two entries buffered.
        press(16'h0002);
        press(16'h0004);
        check("t6_buffered", key_valid, 1);
        hold(16'h0008, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_code", key_code, 0);
        check("t6_rst_multi", multi_key, 0);
        check("t6_rst_ovf", overflow, 0);
        hold(16'h0008, 15);
        check("t6_fresh_at_15", key_valid, 0);
        tick();
        check("t6_fresh_valid", key_valid, 1);
        check("t6_fresh_code", key_code, 3);
        key_ready = 1'b1;
        tick();
        check("t6_single_entry", key_valid, 0);
        key_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_decoder.md
Name: keypad_decoder

Overview:
- Consumer end of the keypad scan path. Takes the 16-bit one-hot key position word produced by the column/row scanner and converts it to a 4-bit key code.
- Debounces both press and release, so each physical press produces exactly one event.
- Buffers events in a small FIFO with a valid/ready handshake toward the display/calculator logic.
- Flags multi-key and FIFO-overflow conditions.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clk edges a sample must be stable before a press or release is accepted. Must be ≥2.
- FIFO_DEPTH, 4: event FIFO entries. Power of two, ≥2.
- CNT_W, 8: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- posicion  in  16  one-hot key position; bit i = key i (bit0 = F1C1 … bit15 = F4C4); all-zero = no key
- key_code  out  4  code of the oldest buffered press (index of the set bit); valid only while key_valid=1
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts key_code; a pop occurs on an edge where key_valid && key_ready
- multi_key  out  1  registered flag: previous sample had more than one bit set
- overflow  out  1  sticky flag: a press was dropped because the FIFO was full; cleared only by rst

Behaviour:

Reset (synchronous, rst=1 at a clk edge):
- State machine goes to IDLE, counter=0, FIFO emptied.
- key_valid=0, key_code=0, multi_key=0, overflow=0.
- A reset mid-debounce or mid-press discards the in-progress press.

Sample classification, combinational, every edge:
- ZERO: posicion==0.
- ONEHOT(c): exactly one bit set; c = its index.
- MULTI: any other value. multi_key <= (class==MULTI).

FSM states: IDLE, DEB_PRESS, PRESSED, DEB_REL.
- IDLE:
  - ONEHOT(c) → cand<=c, cnt<=1, go DEB_PRESS.
  - Otherwise stay.
- DEB_PRESS:
  - ONEHOT(cand) and cnt==DEBOUNCE_CYCLES-1 → push cand into FIFO, go PRESSED.
  - ONEHOT(cand) with cnt below that limit → cnt++.
  - ONEHOT(c≠cand) → cand<=c, cnt<=1 (restart).
  - ZERO or MULTI → go IDLE.
- PRESSED:
  - ZERO → cnt<=1, go DEB_REL.
  - Any non-zero value, including a different key (no rollover) or MULTI → stay, nothing pushed.
- DEB_REL:
  - ZERO and cnt==DEBOUNCE_CYCLES-1 → go IDLE.
  - ZERO with cnt below that limit → cnt++.
  - Non-zero → go PRESSED.

Latency:
- An input that is ONEHOT(c) for DEBOUNCE_CYCLES consecutive edges, starting from IDLE, is pushed on the last of those edges.
- key_valid rises, with key_code=c, after that edge (visible the following cycle).
- After a press has been accepted, the next press is accepted only after DEBOUNCE_CYCLES ZERO samples followed by a new full press debounce.

FIFO:
- First-word-fall-through; key_code is the head entry. key_code holds its value when the FIFO is empty.
- Push onto a full FIFO without a pop on the same edge → entry dropped, overflow<=1.
- Simultaneous push and pop when full → both occur, no overflow.
- Simultaneous push and pop when empty → the push takes effect, the pop is ignored (key_valid was 0).
- Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter has width log2(FIFO_DEPTH)+1.
- key_ready is ignored while key_valid=0.

Decomposition:
- Shared package keypad_pkg:
  - State enum (IDLE, DEB_PRESS, PRESSED, DEB_REL).
  - KEY_W=4 and POS_W=16.
  - Function onehot_to_code, returning index plus an is_onehot flag.
- One sub-module keypad_fifo, parameterised by width and depth. Provides push, pop, full, empty and head outputs.
- FSM and debounce counter stay in keypad_decoder.

Test Plan:
- Reset then hold posicion=0x0020 for 16 edges → key_valid=1, key_code=5 after the 16th edge; exactly one entry; holding the key longer adds none.
- posicion=0x0020 for 10 edges, then 0, then 0x0020 for 16 edges → exactly one event, code 5; the short burst produces nothing.
- Press 0x0001, release for 16 edges, press 0x8000 with key_ready=1 → codes 0 then 15 delivered in order; pops occur only on valid&&ready edges.
- posicion=0x0011 → multi_key=1 the next cycle; no event pushed; FSM stays IDLE.
- key_ready=0; five distinct debounced presses (codes 1,2,3,4,6) → FIFO holds 1,2,3,4; overflow=1 after the 5th; draining yields 1,2,3,4, then key_valid=0.
- Assert rst during DEB_PRESS and while the FIFO holds 2 entries → next cycle all outputs 0; a subsequent 16-edge press yields a single fresh event.
